// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MUL (shift-add) and signed DIV (restoring)
// unit that sits beside the ALU in EX and stalls the pipeline until the
// result is ready.
//
// Handshake: a request is taken when the unit is IDLE and start=1 with a
// MUL/DIV code and no flush in the same cycle; stall is raised in that very
// cycle and stays high through the run states. done pulses for one cycle
// with result/div_by_zero valid; stall is already low in that cycle so the
// pipeline advances together with the pulse.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam logic [3:0] CTRL_MUL = 4'b0111;
    localparam logic [3:0] CTRL_DIV = 4'b0100;
    localparam int         MSB      = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL_RUN = 2'd1,
        S_DIV_RUN = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;     // product accumulator (MUL) / partial remainder (DIV)
    logic [WIDTH-1:0] r_opa;     // multiplicand (MUL) / dividend shifting into quotient (DIV)
    logic [WIDTH-1:0] r_opb;     // multiplier (MUL) / divisor magnitude (DIV)
    logic             r_neg;     // quotient must be negated at the end
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_dbz;

    logic             w_is_mul;
    logic             w_is_div;
    logic             w_accept;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_prod_next;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_quo_signed;

    // Request decode and the datapath for one MUL or DIV iteration
    always_comb begin
        w_is_mul    = (alu_ctrl == CTRL_MUL);
        w_is_div    = (alu_ctrl == CTRL_DIV);
        w_accept    = (r_state == S_IDLE) && start && (w_is_mul || w_is_div) && !flush;
        w_abs_a     = operand_a[MSB] ? -operand_a : operand_a;
        w_abs_b     = operand_b[MSB] ? -operand_b : operand_b;
        w_prod_next = r_acc + (r_opb[0] ? r_opa : '0);
        // Remainder < divisor <= 2^(WIDTH-1), so one extra bit holds the shifted value
        w_rem_sh    = {r_acc, r_opa[MSB]};
        w_diff      = w_rem_sh - {1'b0, r_opb};
        w_ge        = !w_diff[WIDTH];
        w_rem_next  = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        w_quo_next  = {r_opa[WIDTH-2:0], w_ge};
        // Negation wraps naturally, so MIN / -1 yields MIN without a flag
        w_quo_signed = r_neg ? -w_quo_next : w_quo_next;
    end

    // Sequencer FSM with registered busy/done/result/div_by_zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= CNT_W'(WIDTH);
                        r_acc <= '0;
                        r_dbz <= 1'b0;
                        if (w_is_div) begin
                            r_opa <= w_abs_a;
                            r_opb <= w_abs_b;
                            r_neg <= operand_a[MSB] ^ operand_b[MSB];
                            if (operand_b == '0) begin
                                r_state  <= S_DONE;
                                r_done   <= 1'b1;
                                r_dbz    <= 1'b1;
                                r_result <= '1;
                            end else begin
                                r_state <= S_DIV_RUN;
                                r_busy  <= 1'b1;
                            end
                        end else begin
                            r_opa   <= operand_a;
                            r_opb   <= operand_b;
                            r_neg   <= 1'b0;
                            r_state <= S_MUL_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_MUL_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_prod_next;
                        r_opa <= r_opa << 1;
                        r_opb <= r_opb >> 1;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_prod_next;
                        end
                    end
                end
                S_DIV_RUN: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_rem_next;
                        r_opa <= w_quo_next;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_quo_signed;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall       = w_accept || (r_state == S_MUL_RUN) || (r_state == S_DIV_RUN);
    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign div_by_zero = r_dbz;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized checks of muldiv_sequencer
// against a cycle-timestamp reference model built from the latency rules.
module tb_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [3:0] C_MUL = 4'b0111;
    localparam logic [3:0] C_DIV = 4'b0100;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         flush;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alu_ctrl    (alu_ctrl),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = a * b;
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        return q[W-1:0];
    endfunction

    // Reference model: an accepted op finishes at a known cycle index
    int           cyc = 0;
    bit           m_op_valid = 1'b0;
    int           m_done_cyc = 0;
    logic [W-1:0] m_pend = '0;
    logic [W-1:0] m_result = '0;
    logic         m_dbz = 1'b0;
    logic         m_idle;
    logic         m_run;
    logic         m_code_ok;

    assign m_idle    = !m_op_valid || (cyc > m_done_cyc);
    assign m_run     = m_op_valid && (cyc < m_done_cyc);
    assign m_code_ok = (alu_ctrl == C_MUL) || (alu_ctrl == C_DIV);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_op_valid <= 1'b0;
            m_result   <= '0;
            m_dbz      <= 1'b0;
        end else if (m_run && flush) begin
            m_op_valid <= 1'b0;
        end else if (m_idle && start && m_code_ok && !flush) begin
            m_op_valid <= 1'b1;
            if (alu_ctrl == C_DIV && operand_b == '0) begin
                m_done_cyc <= cyc + 1;
                m_result   <= '1;
                m_dbz      <= 1'b1;
            end else begin
                m_done_cyc <= cyc + 1 + W;
                m_pend     <= (alu_ctrl == C_MUL) ? ref_mul(operand_a, operand_b)
                                                  : ref_div(operand_a, operand_b);
                m_dbz      <= 1'b0;
            end
        end else if (m_op_valid && (cyc + 1 == m_done_cyc)) begin
            m_result <= m_pend;
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", stall, m_run || (m_idle && start && m_code_ok && !flush));
            chk("busy", busy, m_run);
            chk("done", done, m_op_valid && (cyc == m_done_cyc));
            chk("result", result, m_result);
            chk("div_by_zero", div_by_zero, m_dbz);
        end
    end

    // Driver: present a request for exactly one cycle
    task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        start = 1'b1; alu_ctrl = c; operand_a = a; operand_b = b; flush = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Bounded wait for done; lat counts cycles after the accept edge
    task automatic wait_done(output int lat, output bit ok);
        ok = 1'b0;
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                lat = i;
                break;
            end
        end
    endtask

    task automatic no_done_for(input int n, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk(name, seen, 1'b0);
    endtask

    task automatic directed(input string name, input logic [3:0] c, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp_res,
                            input logic exp_dbz, input int exp_lat);
        int lat;
        bit ok;
        issue(c, a, b);
        wait_done(lat, ok);
        chk({name, "_done_seen"}, ok, 1'b1);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_result"}, result, exp_res);
        chk({name, "_dbz"}, div_by_zero, exp_dbz);
    endtask

    initial begin
        int lat;
        bit ok;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0] c;
        int sel;

        reset = 1'b1; start = 1'b0; alu_ctrl = 4'b0; operand_a = '0; operand_b = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_stall", stall, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_result", result, 32'h0);
        chk("reset_dbz", div_by_zero, 1'b0);
        chk("reset_state", dbg_state, 2'd0);

        // Unsupported code is ignored
        @(posedge clk); #1;
        start = 1'b1; alu_ctrl = 4'b0010; operand_a = 32'd9; operand_b = 32'd3;
        @(negedge clk);
        chk("bad_code_stall", stall, 1'b0);
        @(posedge clk); #1 start = 1'b0;
        no_done_for(5, "bad_code_no_done");

        // Start together with flush in IDLE is not accepted
        @(posedge clk); #1;
        start = 1'b1; alu_ctrl = C_MUL; flush = 1'b1;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_busy", busy, 1'b0);

        directed("mul_7x6", C_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 32);
        directed("mul_ffff_x2", C_MUL, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0, 32);
        directed("div_m100_7", C_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0, 32);
        directed("div_ovf", C_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 32);
        directed("div_by_zero", C_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 0);

        // Flush a MUL at iteration 10: no done, result keeps its value
        issue(C_MUL, 32'd1234, 32'd5678);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy, 1'b0);
        chk("flush_state", dbg_state, 2'd0);
        no_done_for(40, "flush_no_done");
        chk("flush_result_held", result, 32'hFFFFFFFF);
        directed("mul_3x3", C_MUL, 32'd3, 32'd3, 32'd9, 1'b0, 32);

        // Reset at DIV iteration 20
        issue(C_DIV, 32'd1000, 32'd7);
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_result", result, 32'h0);
        chk("midreset_state", dbg_state, 2'd0);
        no_done_for(40, "midreset_no_done");

        // Start during the DONE cycle is ignored
        issue(C_MUL, 32'd11, 32'd13);
        wait_done(lat, ok);
        chk("done_start_first", ok, 1'b1);
        chk("done_start_result", result, 32'd143);
        #2 start = 1'b1; alu_ctrl = C_DIV; operand_a = 32'd50; operand_b = 32'd5;
        @(posedge clk); #1 start = 1'b0;
        no_done_for(40, "done_start_ignored");

        // Randomized operations with occasional flush and stray starts
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            c = (sel < 4) ? C_MUL : (sel < 8) ? C_DIV : 4'($urandom_range(0, 15));
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            issue(c, a, b);
            if (c != C_MUL && c != C_DIV) begin
                repeat (2) @(posedge clk);
            end else if (c == C_DIV && b == '0) begin
                repeat (2) @(posedge clk);
            end else if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(0, 31)) @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk); #1 flush = 1'b0;
                repeat (2) @(posedge clk);
            end else begin
                if ($urandom_range(0, 2) == 0) begin
                    repeat (5) @(posedge clk);
                    #1 start = 1'b1; alu_ctrl = C_MUL;
                    @(posedge clk); #1 start = 1'b0;
                end
                wait_done(lat, ok);
                chk("rand_done_seen", ok, 1'b1);
            end
        end
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the ALU control codes 4'b0111 (MUL) and 4'b0100 (DIV).
- Accepts an operation from the execute stage and computes it iteratively: shift-add for MUL, restoring division for DIV.
- Holds the pipeline via `stall` until the result is ready.
- Sits beside the ALU in EX and is selected whenever ALU control decodes one of these two codes.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- alu_ctrl  input  4  ALU control code: 4'b0111 = MUL, 4'b0100 = DIV; any other code is ignored.
- operand_a  input  WIDTH  multiplicand / dividend; captured on accept.
- operand_b  input  WIDTH  multiplier / divisor; captured on accept.
- flush  input  1  pipeline flush; aborts the operation in progress.
- stall  output  1  hold request to the pipeline (combinational).
- busy  output  1  registered; high while in MUL_RUN or DIV_RUN.
- done  output  1  one-cycle pulse; result is valid.
- result  output  WIDTH  product low WIDTH bits, or signed quotient.
- div_by_zero  output  1  registered flag; set with `done` when the divisor was 0.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - stall, busy, done, div_by_zero = 0; result = 0.
  - Counter and internal accumulators are cleared.
  - Reset overrides start and flush.
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- Accept: in IDLE, with start=1 and alu_ctrl ∈ {0111, 0100}, operands are captured at the clock edge.
  - Next state is MUL_RUN or DIV_RUN.
  - Counter is set to WIDTH.
  - `done` and `div_by_zero` clear on accept.
- Ignored requests:
  - start with any other alu_ctrl: ignored, stall stays 0.
  - start outside IDLE: ignored.
- stall = (IDLE & start & valid code & !flush) | MUL_RUN | DIV_RUN.
  - stall is 0 in DONE, so the pipeline advances in the same cycle `done` is high.
- MUL_RUN: one iteration per cycle.
  - If multiplier LSB = 1, add multiplicand into the accumulator.
  - Shift multiplicand left and multiplier right; decrement the counter.
  - At counter = 1, the next state is DONE.
  - Result = low WIDTH bits of the product. This is sign-agnostic, so no sign handling is needed.
- DIV_RUN: signed DIV.
  - On accept, the magnitudes of both operands are stored and quotient sign = a[MSB] ^ b[MSB].
  - Each cycle performs one restoring step: shift the remainder left and bring in the next dividend bit; subtract the divisor; if non-negative, keep the difference and shift in quotient bit 1, otherwise shift in 0.
  - After WIDTH iterations, the next state is DONE and result = quotient, negated if the sign bit is set.
- Divide by zero: on accept with operand_b = 0 and DIV, the block goes directly to DONE in the next cycle with result = all-ones and div_by_zero = 1.
- Overflow: (-2^(WIDTH-1)) / (-1) gives result = 2^(WIDTH-1) bit pattern (0x80000000), via natural wrap. No flag is raised.
- Latency:
  - Accept at edge N; `done` = 1 in cycle N+WIDTH+1, i.e. cycle N+33 for WIDTH=32.
  - Divide by zero: `done` = 1 in cycle N+1.
- DONE: `done` = 1 for exactly one cycle, then the state returns to IDLE.
  - result and div_by_zero hold their values until the next accept or reset.
  - A start arriving in the DONE cycle is ignored. The requester re-presents it in IDLE.
- Flush:
  - In MUL_RUN or DIV_RUN: the next state is IDLE, no `done` pulse, result unchanged, stall drops in the following cycle.
  - In IDLE together with start: the request is not accepted.
  - In DONE: no effect; `done` still pulses.
- busy = registered (state ∈ {MUL_RUN, DIV_RUN}).

Test Plan:
- Reset for 2 cycles, then release → all outputs 0, state IDLE; start with alu_ctrl=4'b0010 → stall stays 0, no `done`.
- MUL, a=7, b=6 → stall high for 33 cycles including the accept cycle; done at N+33 with result=42. Repeat with a=0xFFFFFFFF, b=2 → result=0xFFFFFFFE.
- DIV, a=-100 (0xFFFFFF9C), b=7 → result=-14 (0xFFFFFFF2), div_by_zero=0, done at N+33. Repeat with a=0x80000000, b=0xFFFFFFFF → result=0x80000000.
- DIV, a=5, b=0 → done at N+1, result=0xFFFFFFFF, div_by_zero=1, stall high only in the accept cycle.
- MUL started, then flush at iteration 10 → state IDLE next cycle, no done pulse, result keeps its previous value; a new MUL 3×3 then gives 9.
- Reset asserted mid-DIV at iteration 20 → outputs zero next cycle; start asserted in the DONE cycle → ignored, no second done.
